dma_engine: RTL and testbench

- Bus-master DMA controller that moves a block of data from an external device into data memory, 4-word lines at a time.
- The CPU issues a command word. The engine then requests the data bus (BR) and waits for the grant (BG).
- While granted, it writes each line from the device to memory, then releases the bus and raises a one-cycle completion interrupt to the CPU.
- It sits between the CPU's bus arbiter, the memory's line-write port (the bench muxes addr/data onto memory when BG=1) and the external device's 64-bit data window.

---
 rtl/dma_engine_pkg.sv | 32 +++
 rtl/dma_engine_if.sv | 25 ++
 rtl/dma_engine.sv | 116 +++++++++++
 tb/tb_dma_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_engine_pkg.sv
// rtl/dma_engine_pkg.sv - shared constants, command field positions and FSM states for the DMA engine
package dma_engine_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int LINE_WORDS  = 4;
    localparam int LINE_SIZE   = WORD_SIZE * LINE_WORDS;
    localparam int MEM_LATENCY = 4;
    localparam int CNT_W       = $clog2(MEM_LATENCY);
    localparam int ADDR_W      = 16;
    localparam int OFFSET_W    = 2;

    localparam int CMD_GO      = 15;
    localparam int CMD_LEN_HI  = 13;
    localparam int CMD_LEN_LO  = 12;
    localparam int CMD_ADDR_HI = 11;
    localparam int CMD_ADDR_LO = 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        DONE,
        WAIT_CLR
    } dma_state_e;

    // Word address of a line: base plus LINE_WORDS words per line, 16-bit wrap.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [OFFSET_W-1:0] off);
        return base + ADDR_W'({off, 2'b00});
    endfunction

endpackage

// File: rtl/dma_engine_if.sv
// rtl/dma_engine_if.sv - command, arbiter, memory line-write and device window signals of the DMA engine
interface dma_engine_if;
    import dma_engine_pkg::*;

    logic [WORD_SIZE-1:0] cmd;
    logic                 BG;
    logic [LINE_SIZE-1:0] edata;
    logic                 BR;
    logic                 WRITE;
    logic [ADDR_W-1:0]    addr;
    logic [LINE_SIZE-1:0] data;
    logic [OFFSET_W-1:0]  offset;
    logic                 interrupt;

    modport master (
        input  cmd, BG, edata,
        output BR, WRITE, addr, data, offset, interrupt
    );

    modport slave (
        output cmd, BG, edata,
        input  BR, WRITE, addr, data, offset, interrupt
    );

endinterface

// File: rtl/dma_engine.sv
// rtl/dma_engine.sv - bus-master DMA moving 1..4 device lines into memory, then pulsing an interrupt
module dma_engine
    import dma_engine_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    dma_engine_if.master  bus
);

    dma_state_e           state_q,  state_d;
    logic [ADDR_W-1:0]    base_q,   base_d;
    logic [OFFSET_W-1:0]  last_q,   last_d;
    logic [OFFSET_W-1:0]  offset_q, offset_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [ADDR_W-1:0]    addr_q,   addr_d;
    logic                 br_q,     br_d;
    logic                 irq_q,    irq_d;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{bus.cmd[14], bus.cmd[CMD_ADDR_LO-1:0]};

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        last_d   = last_q;
        offset_d = offset_q;
        cnt_d    = cnt_q;
        br_d     = 1'b0;
        irq_d    = 1'b0;
        addr_d   = '0;

        case (state_q)
            IDLE: begin
                if (bus.cmd[CMD_GO]) begin
                    base_d   = {4'b0, bus.cmd[CMD_ADDR_HI:CMD_ADDR_LO], 2'b00};
                    last_d   = bus.cmd[CMD_LEN_HI:CMD_LEN_LO];
                    offset_d = '0;
                    cnt_d    = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.BG) begin
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                // Losing the grant discards the partial line; it restarts from cycle 0.
                if (!bus.BG) begin
                    cnt_d   = '0;
                    state_d = REQ;
                end else if (cnt_q == CNT_W'(MEM_LATENCY - 1)) begin
                    cnt_d = '0;
                    if (offset_q == last_q) begin
                        state_d = DONE;
                    end else begin
                        offset_d = offset_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (!bus.cmd[CMD_GO]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        br_d  = (state_d == REQ) || (state_d == XFER);
        irq_d = (state_d == DONE);
        if (br_d) begin
            addr_d = line_addr(base_d, offset_d);
        end else begin
            offset_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            last_q   <= '0;
            offset_q <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            br_q     <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            last_q   <= last_d;
            offset_q <= offset_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            br_q     <= br_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.BR        = br_q;
    assign bus.interrupt = irq_q;
    assign bus.addr      = addr_q;
    assign bus.offset    = offset_q;
    assign bus.WRITE     = (state_q == XFER) && bus.BG;
    assign bus.data      = (state_q == XFER) ? bus.edata : '0;

endmodule

// File: tb/tb_dma_engine.sv
// tb/tb_dma_engine.sv - directed self-checking bench for dma_engine
module tb_dma_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tag;
    int         checks   = 0;
    int         failures = 0;
    int         granted;

    dma_engine_if bus ();

    dma_engine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Device line: each word tags the transfer, the line index and the word index.
    function automatic logic [63:0] line_of(input logic [7:0] t, input logic [1:0] off);
        logic [63:0] r;
        for (int w = 0; w < 4; w++) begin
            r[w*16 +: 16] = {t, 4'h0, off, 2'(w)};
        end
        return r;
    endfunction

    assign bus.edata = line_of(tag, bus.offset);

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [15:0] base, input int l);
        chk({name, "_write"},  64'(bus.WRITE),  64'd1);
        chk({name, "_br"},     64'(bus.BR),     64'd1);
        chk({name, "_addr"},   64'(bus.addr),   64'(base + 16'(4 * l)));
        chk({name, "_offset"}, 64'(bus.offset), 64'(l));
        chk({name, "_data"},   bus.data,        line_of(tag, 2'(l)));
        if (bus.WRITE) granted++;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.cmd = 16'h0000;
        bus.BG  = 1'b0;
        tag     = 8'h00;
        granted = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_br",     64'(bus.BR),        64'd0);
        chk("rst_write",  64'(bus.WRITE),     64'd0);
        chk("rst_irq",    64'(bus.interrupt), 64'd0);
        chk("rst_offset", 64'(bus.offset),    64'd0);
        chk("rst_addr",   64'(bus.addr),      64'd0);
        chk("rst_data",   bus.data,           64'd0);

        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("idle_br",     64'(bus.BR),        64'd0);
            chk("idle_write",  64'(bus.WRITE),     64'd0);
            chk("idle_irq",    64'(bus.interrupt), 64'd0);
            chk("idle_offset", 64'(bus.offset),    64'd0);
        end

        // Three lines from 0x01F4, grant two cycles after the request.
        tag = 8'h11;
        @(negedge clk) bus.cmd = 16'hA1F4;
        @(negedge clk); #1;
        chk("basic_br_req", 64'(bus.BR),    64'd1);
        chk("basic_no_wr",  64'(bus.WRITE), 64'd0);
        @(negedge clk);
        @(negedge clk) bus.BG = 1'b1;
        #1 chk("basic_req_wr", 64'(bus.WRITE), 64'd0);
        granted = 0;
        for (int l = 0; l < 3; l++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk); #1;
                chk_line("basic", 16'h01F4, l);
            end
        end
        @(negedge clk); #1;
        chk("basic_done_br",  64'(bus.BR),        64'd0);
        chk("basic_done_irq", 64'(bus.interrupt), 64'd1);
        chk("basic_done_wr",  64'(bus.WRITE),     64'd0);
        chk("basic_granted",  64'(granted),       64'd12);
        @(negedge clk);
        bus.cmd = 16'h0000;
        bus.BG  = 1'b0;
        #1 chk("basic_irq_pulse", 64'(bus.interrupt), 64'd0);
        @(negedge clk);

        // Grant withdrawn for three cycles after two cycles of line 1.
        tag = 8'h22;
        @(negedge clk) bus.cmd = 16'hA1F4;
        @(negedge clk) bus.BG = 1'b1;
        #1 chk("gap_br_req", 64'(bus.BR), 64'd1);
        granted = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk_line("gap_l0", 16'h01F4, 0);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk_line("gap_l1a", 16'h01F4, 1);
        end
        @(negedge clk) bus.BG = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("gap_write", 64'(bus.WRITE), 64'd0);
            chk("gap_br",    64'(bus.BR),    64'd1);
            @(negedge clk);
        end
        bus.BG = 1'b1;
        #1;
        chk("gap_regrant_wr", 64'(bus.WRITE), 64'd0);
        chk("gap_regrant_br", 64'(bus.BR),    64'd1);
        for (int l = 1; l < 3; l++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk); #1;
                chk_line("gap_tail", 16'h01F4, l);
            end
        end
        @(negedge clk); #1;
        chk("gap_irq",     64'(bus.interrupt), 64'd1);
        chk("gap_granted", 64'(granted),       64'd14);

        // Command left asserted after completion must not retrigger.
        @(negedge clk) bus.BG = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("held_br",  64'(bus.BR),        64'd0);
            chk("held_irq", 64'(bus.interrupt), 64'd0);
        end
        tag = 8'h33;
        @(negedge clk) bus.cmd = 16'h0000;
        @(negedge clk) bus.cmd = 16'h8040;
        @(negedge clk) bus.BG = 1'b1;
        #1 chk("one_br_req", 64'(bus.BR), 64'd1);
        granted = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk_line("one", 16'h0040, 0);
        end
        @(negedge clk); #1;
        chk("one_irq",     64'(bus.interrupt), 64'd1);
        chk("one_br_done", 64'(bus.BR),        64'd0);
        chk("one_granted", 64'(granted),       64'd4);
        @(negedge clk);
        bus.cmd = 16'h0000;
        bus.BG  = 1'b0;
        #1 chk("one_irq_pulse", 64'(bus.interrupt), 64'd0);
        @(negedge clk);

        // Reset in the middle of line 1 aborts the transfer.
        tag = 8'h44;
        @(negedge clk) bus.cmd = 16'hA1F4;
        @(negedge clk) bus.BG = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk_line("abort_l0", 16'h01F4, 0);
        end
        @(negedge clk); #1;
        chk_line("abort_l1", 16'h01F4, 1);
        @(negedge clk);
        reset_n = 1'b0;
        bus.cmd = 16'h0000;
        bus.BG  = 1'b0;
        @(negedge clk); #1;
        chk("abort_br",     64'(bus.BR),        64'd0);
        chk("abort_write",  64'(bus.WRITE),     64'd0);
        chk("abort_offset", 64'(bus.offset),    64'd0);
        chk("abort_irq",    64'(bus.interrupt), 64'd0);
        chk("abort_addr",   64'(bus.addr),      64'd0);
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("abort_after_irq", 64'(bus.interrupt), 64'd0);
            chk("abort_after_br",  64'(bus.BR),        64'd0);
        end

        // Four lines from 0x0FF8 crossing into 0x1000.
        tag = 8'h55;
        @(negedge clk) bus.cmd = 16'hBFF8;
        @(negedge clk) bus.BG = 1'b1;
        #1 chk("wrap_br_req", 64'(bus.BR), 64'd1);
        granted = 0;
        for (int l = 0; l < 4; l++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk); #1;
                chk_line("wrap", 16'h0FF8, l);
            end
        end
        @(negedge clk); #1;
        chk("wrap_irq",     64'(bus.interrupt), 64'd1);
        chk("wrap_granted", 64'(granted),       64'd16);
        @(negedge clk);
        bus.cmd = 16'h0000;
        bus.BG  = 1'b0;
        #1 chk("wrap_irq_pulse", 64'(bus.interrupt), 64'd0);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
